kim_lsu_p: RTL and testbench

KIM_LSU_P -- requirements
Module: kim_lsu_p

---
 rtl/kim_lsu_p.sv | 107 ++++++++++
 tb/tb_kim_lsu_p.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/kim_lsu_p.sv
// kim_lsu_p: load/store unit with byte/half read-modify-write onto a word-wide data memory
module kim_lsu_p #(
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int MEM_DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [31:0]                   req_addr,
  input  logic [4*MEM_DATA_WIDTH-1:0]   req_wdata,
  output logic                          resp_valid,
  output logic [4*MEM_DATA_WIDTH-1:0]   resp_rdata,
  output logic                          resp_err,
  output logic                          mem_MemWrite,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic [4*MEM_DATA_WIDTH-1:0]   mem_w_data,
  input  logic [4*MEM_DATA_WIDTH-1:0]   mem_r_data
);
  localparam int BW = MEM_DATA_WIDTH;
  localparam int DW = 4 * MEM_DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d, bad;
  logic [1:0] size_q, size_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d, merged, ext;
  logic [BW-1:0] b;
  logic [2*BW-1:0] h;
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00) || |req_addr[31:MEM_ADDR_WIDTH];
  end
  // data_q holds the store data until RMW_RD folds it into the fetched word
  always_comb begin
    merged = mem_r_data;
    for (int i = 0; i < 4; i++)
      if (size_q == 2'b00 ? addr_q[1:0] == 2'(i) : addr_q[1] == i[1])
        merged[i*BW +: BW] = (size_q == 2'b01 && i[0]) ? data_q[2*BW-1:BW] : data_q[BW-1:0];
  end
  always_comb begin
    b = data_q[BW*addr_q[1:0] +: BW];
    h = data_q[2*BW*addr_q[1] +: 2*BW];
    ext = size_q == 2'b10 ? data_q :
          size_q == 2'b01 ? {{(DW-2*BW){~uns_q & h[2*BW-1]}}, h} :
                            {{(DW-BW){~uns_q & b[BW-1]}}, b};
  end
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    uns_d = uns_q;
    err_d = err_q;
    size_d = size_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d = req_we;
        uns_d = req_unsigned;
        err_d = bad;
        size_d = req_size;
        addr_d = req_addr[MEM_ADDR_WIDTH-1:0];
        data_d = req_wdata;
        state_d = bad ? RESP : !req_we ? ACCESS : req_size == 2'b10 ? WRITE : RMW_RD;
      end
      ACCESS: begin
        data_d = mem_r_data;
        state_d = RESP;
      end
      RMW_RD: begin
        data_d = merged;
        state_d = WRITE;
      end
      WRITE: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      uns_q <= uns_d;
      err_q <= err_d;
      size_q <= size_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign req_ready    = state_q == IDLE && !reset;
  assign mem_MemWrite = state_q == WRITE && !reset;
  assign mem_addr     = state_q == IDLE ? '0 : {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
  assign mem_w_data   = data_q;
  assign resp_valid   = state_q == RESP;
  assign resp_err     = resp_valid && err_q;
  assign resp_rdata   = (resp_valid && !err_q && !we_q) ? ext : '0;
endmodule

// File: tb/tb_kim_lsu_p.sv
// tb_kim_lsu_p: random and directed load/store traffic against a byte-array reference model
module tb_kim_lsu_p;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_err, mem_MemWrite;
  logic [31:0] resp_rdata, mem_w_data, mem_r_data;
  logic [5:0] mem_addr;
  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  kim_lsu_p dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_MemWrite(mem_MemWrite),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  assign mem_r_data = {mem[{mem_addr[5:2], 2'd3}], mem[{mem_addr[5:2], 2'd2}],
                       mem[{mem_addr[5:2], 2'd1}], mem[{mem_addr[5:2], 2'd0}]};
  always @(posedge clk)
    if (mem_MemWrite)
      for (int i = 0; i < 4; i++) mem[{mem_addr[5:2], 2'(i)}] <= mem_w_data[i*8 +: 8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mem_cmp(input string tag);
    int diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk(tag, diffs, 0);
  endtask

  task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit keep, input string tag);
    logic [5:0] la, al;
    logic [7:0] v;
    logic [15:0] hv;
    logic [31:0] exp_rd, exp_wd, got_rd, wdat;
    logic [5:0] wa;
    bit exp_err, got_err, busy_ok;
    int exp_lat, lat, resp_n, wr, waits;
    la = a[5:0];
    al = {la[5:2], 2'b00};
    exp_err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) || a[31:6] != 0;
    exp_lat = exp_err ? 1 : (!we || sz == 2'd2) ? 2 : 3;
    exp_rd = 0;
    exp_wd = 0;
    if (!exp_err && !we) begin
      v = ref_mem[la];
      hv = {ref_mem[la + 1], ref_mem[la]};
      exp_rd = sz == 2'd2 ? {ref_mem[al + 3], ref_mem[al + 2], ref_mem[al + 1], ref_mem[al]} :
               sz == 2'd1 ? (uns ? {16'h0, hv} : {{16{hv[15]}}, hv}) :
                            (uns ? {24'h0, v} : {{24{v[7]}}, v});
    end
    if (!exp_err && we) begin
      if (sz == 2'd2) for (int i = 0; i < 4; i++) ref_mem[al + i] = wd[i*8 +: 8];
      else begin
        ref_mem[la] = wd[7:0];
        if (sz == 2'd1) ref_mem[la + 1] = wd[15:8];
      end
      exp_wd = {ref_mem[al + 3], ref_mem[al + 2], ref_mem[al + 1], ref_mem[al]};
    end
    @(negedge clk);
    req_valid = 1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      req_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 0;
    lat = 0;
    resp_n = 0;
    wr = 0;
    busy_ok = 1;
    got_rd = 0;
    got_err = 0;
    wa = 0;
    wdat = 0;
    for (int k = 1; k <= exp_lat; k++) begin
      @(negedge clk);
      if (req_ready) busy_ok = 0;
      if (resp_valid) begin
        resp_n++;
        lat = k;
        got_rd = resp_rdata;
        got_err = resp_err;
      end else if (resp_err || resp_rdata != 0) busy_ok = 0;
      if (mem_MemWrite) begin
        wr++;
        wa = mem_addr;
        wdat = mem_w_data;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_nresp"}, resp_n, 1);
    chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
    chk({tag, "_rdata"}, got_rd, exp_rd);
    chk({tag, "_nwrite"}, wr, (we && !exp_err) ? 1 : 0);
    chk({tag, "_busy"}, 32'(busy_ok), 1);
    if (we && !exp_err) begin
      chk({tag, "_waddr"}, 32'(wa), 32'(al));
      chk({tag, "_wdata"}, wdat, exp_wd);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[16] = 8'h11;
    mem[17] = 8'h22;
    mem[18] = 8'h33;
    mem[19] = 8'h84;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_we", 32'(mem_MemWrite), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_ready", 32'(req_ready), 1);

    do_op(0, 2'd0, 0, 32'h13, 0, 0, "lb13");
    do_op(0, 2'd0, 1, 32'h13, 0, 0, "lbu13");
    do_op(1, 2'd1, 0, 32'h12, 32'h0000BEEF, 0, "sh12");
    do_op(0, 2'd2, 0, 32'h10, 0, 0, "lw10");
    do_op(0, 2'd2, 0, 32'h12, 0, 0, "lw12_mis");
    do_op(1, 2'd2, 0, 32'h40, 32'hDEADBEEF, 0, "sw40_oor");
    do_op(1, 2'd3, 0, 32'h20, 32'h12345678, 0, "sz3");
    mem_cmp("mem_after_err");

    @(negedge clk);
    req_valid = 1;
    req_we = 1;
    req_size = 2'd0;
    req_addr = 32'h11;
    req_wdata = 32'hAB;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_pre_we", 32'(mem_MemWrite), 1);
    reset = 1;
    #1 chk("rstw_we", 32'(mem_MemWrite), 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rstw_ready", 32'(req_ready), 1);
    chk("rstw_valid", 32'(resp_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rstw_noresp", 32'(resp_valid | mem_MemWrite), 0);
    end
    chk("rstw_byte", 32'(mem[17]), 32'h22);
    mem_cmp("mem_after_rst");

    for (int i = 0; i < 6; i++)
      case (i % 3)
        0: do_op(0, 2'd2, 0, 32'h20 + 32'(4 * i), 0, 1, "b2b_lw");
        1: do_op(1, 2'd2, 0, 32'h20 + 32'(4 * i), $urandom, 1, "b2b_sw");
        default: do_op(1, 2'd0, 0, 32'h21 + 32'(4 * i), $urandom, i != 5, "b2b_sb");
      endcase

    for (int i = 0; i < 80; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        a = sz == 2'd2 ? {a[31:2], 2'b00} : sz == 2'd1 ? {a[31:1], 1'b0} : a;
      do_op(1'($urandom), sz, 1'($urandom), a, $urandom, 0, "rnd");
    end
    mem_cmp("mem_final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
